argmax_feeder: RTL and testbench
================================

ARGMAX_FEEDER -- requirements
Module: argmax_feeder

Interface
REQ-001 SHALL have one clock and an asynchronous active-low reset.
- clk  input  1  rising-edge clock
- rst_n  input  1  async active-low reset
REQ-002 SHALL have the following ports:
- in_data  input  8  serial sample
- in_valid  input  1  in_data is valid
- in_last  input  1  final sample of a short vector; qualified by in_valid
- in_ready  output  1  block accepts a sample this cycle
- clr  input  1  sync discard of partial and held vectors
- x0..x9  output  8 each  parallel vector to the argmax comparator tree
- vec_len  output  4  number of real samples in the vector, 1..10
- vec_valid  output  1  x0..x9 and vec_len are stable and complete
- vec_ready  input  1  consumer takes the vector

Function
REQ-003 SHALL use a two-state FSM {FILL, HOLD} and a 4-bit write counter wcnt, range 0..9.
REQ-004 A sample SHALL be accepted when in_valid && in_ready on a rising clk edge.
- Stored to entry wcnt.
- wcnt increments.
REQ-005 in_ready SHALL be 1 in FILL and 0 in HOLD, except as allowed by REQ-016.
REQ-006 FILL->HOLD SHALL occur on accepting the sample at wcnt==9, or on accepting any sample with in_last=1.
- On this transition, vec_len = number of samples accepted.
- wcnt returns to 0.
REQ-007 On a short vector, entries at index >= vec_len SHALL be driven as 8'h00.
REQ-008 in_last on the 10th sample SHALL be redundant: vec_len = 10, with no extra effect.
REQ-009 Latency: vec_valid SHALL rise on the cycle after the completing sample is accepted.
REQ-010 In HOLD, vec_valid SHALL be 1, and x0..x9 and vec_len SHALL hold constant until vec_ready.
REQ-011 HOLD with vec_ready=1 SHALL return to FILL on that edge.
- vec_valid drops the following cycle.
- Stored entries clear to 0.
REQ-012 vec_ready while vec_valid=0 SHALL be ignored.
REQ-013 A clr edge SHALL force FILL, wcnt=0, vec_valid=0, and all entries 0.
- The sample offered in the same cycle is dropped.
- clr overrides in_valid and vec_ready in the same cycle.
REQ-014 in_valid with in_ready=0 SHALL have no effect; the source holds the sample.

Reset
REQ-015 While rst_n=0, all outputs SHALL be forced asynchronously.
- x0..x9 = 0, vec_len = 0, vec_valid = 0, state = FILL, wcnt = 0.
- in_ready = 1 once rst_n is released.
- Reset mid-fill or mid-hold discards all data.

Configuration
REQ-016 Macro ARGMAX_FEEDER_PINGPONG_EN:
- Defined: two storage banks, ping-pong.
 - While one bank is held for the consumer, in_ready stays 1 and fills the other bank.
 - Vectors are presented in arrival order.
 - in_ready = 0 only when both banks are complete and unconsumed.
 - If the held vector is consumed on the same edge the other bank completes, the new vector is presented with vec_valid staying 1, no gap.
 - clr discards both banks.
- Undefined: single bank only; behaviour per REQ-005..REQ-013.

Verification
REQ-017 Bench SHALL cover these scenarios:
- Full vector: feed 10..19 back-to-back, vec_ready=0 -> vec_valid at cycle 11, x0=10..x9=19, vec_len=10, in_ready=0 until vec_ready.
- Short vector: feed 5, 7, 3 with in_last on 3 -> x0=5, x1=7, x2=3, x3..x9=0, vec_len=3.
- Handshake: hold vec_valid 5 cycles, then pulse vec_ready -> outputs stable for all 5 cycles, then vec_valid=0 and in_ready=1 the next cycle.
- clr mid-fill: after 4 samples assert clr with in_valid=1 -> no vector emitted; the next 10 samples form a vector starting at x0.
- Reset mid-hold: rst_n low while vec_valid=1 -> all outputs 0 immediately, in_ready=1 after release.
- Ping-pong (macro defined): stream 20 samples continuously with vec_ready held high -> in_ready stays 1 throughout; two vectors delivered in order.

Source files
------------

// File: rtl/argmax_feeder.sv
// rtl/argmax_feeder.sv - serial-to-parallel vector feeder for the argmax comparator tree
//
// Purpose: collects up to ten 8-bit samples arriving one per handshake into a
// parallel vector x0..x9. A vector completes on the tenth sample or on a
// sample flagged in_last. The completed vector is held with vec_valid until
// the consumer takes it with vec_ready. Entries past vec_len read as zero.
//
// Ports:
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   in_data/in_valid    serial sample and its qualifier
//   in_last             marks the final sample of a short vector
//   in_ready            a sample offered this cycle is accepted
//   clr                 synchronous discard of partial and held vectors
//   x0..x9              parallel vector to the comparator tree
//   vec_len             number of real samples in the vector, 1..10
//   vec_valid/vec_ready vector handshake
//
// Build option: ARGMAX_FEEDER_PINGPONG_EN selects two ping-pong banks, so a
// new vector can fill while the previous one is held. Without it a single
// bank is used and input stalls while a vector is held.

module argmax_feeder (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] in_data,
   input  logic       in_valid,
   input  logic       in_last,
   output logic       in_ready,
   input  logic       clr,
   output logic [7:0] x0,
   output logic [7:0] x1,
   output logic [7:0] x2,
   output logic [7:0] x3,
   output logic [7:0] x4,
   output logic [7:0] x5,
   output logic [7:0] x6,
   output logic [7:0] x7,
   output logic [7:0] x8,
   output logic [7:0] x9,
   output logic [3:0] vec_len,
   output logic       vec_valid,
   input  logic       vec_ready
);

   logic [3:0] wcnt;
   logic [7:0] xv [10];
   logic       accept;
   logic       completes;
   logic [3:0] wcnt_inc;

   assign accept    = in_valid && in_ready;
   // in_last on the tenth sample is redundant: the wcnt==9 term already completes it
   assign completes = in_last || (wcnt == 4'd9);
   assign wcnt_inc  = wcnt + 4'd1;

`ifdef ARGMAX_FEEDER_PINGPONG_EN

   logic [7:0] mem [2][10];
   logic [3:0] len_q [2];
   logic [1:0] full;
   logic       wbank;
   logic       rbank;
   logic       consume;

   // wbank is full only when it is waiting behind the presented bank,
   // i.e. both banks are complete and unconsumed
   assign in_ready  = !full[wbank];
   assign vec_valid = full[rbank];
   assign vec_len   = len_q[rbank];
   assign consume   = vec_valid && vec_ready;

   always_comb begin
      for (int i = 0; i < 10; i++) xv[i] = mem[rbank][i];
   end

   // A consumed bank is always full and a filling bank never is, so the
   // consume and accept branches never touch the same bank on one edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wcnt  <= 4'd0;
         full  <= 2'b00;
         wbank <= 1'b0;
         rbank <= 1'b0;
         for (int b = 0; b < 2; b++) begin
            len_q[b] <= 4'd0;
            for (int i = 0; i < 10; i++) mem[b][i] <= 8'h00;
         end
      end else if (clr) begin
         wcnt  <= 4'd0;
         full  <= 2'b00;
         wbank <= 1'b0;
         rbank <= 1'b0;
         for (int b = 0; b < 2; b++) begin
            len_q[b] <= 4'd0;
            for (int i = 0; i < 10; i++) mem[b][i] <= 8'h00;
         end
      end else begin
         if (consume) begin
            full[rbank]  <= 1'b0;
            len_q[rbank] <= 4'd0;
            rbank        <= ~rbank;
            for (int i = 0; i < 10; i++) mem[rbank][i] <= 8'h00;
         end
         if (accept) begin
            mem[wbank][wcnt] <= in_data;
            if (completes) begin
               full[wbank]  <= 1'b1;
               len_q[wbank] <= wcnt_inc;
               wcnt         <= 4'd0;
               wbank        <= ~wbank;
            end else begin
               wcnt <= wcnt_inc;
            end
         end
      end
   end

`else

   localparam logic [0:0] FILL = 1'b0;
   localparam logic [0:0] HOLD = 1'b1;

   logic [0:0] state;
   logic [7:0] mem [10];
   logic [3:0] len_q;

   assign in_ready  = (state == FILL);
   assign vec_valid = (state == HOLD);
   assign vec_len   = len_q;

   always_comb begin
      for (int i = 0; i < 10; i++) xv[i] = mem[i];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= FILL;
         wcnt  <= 4'd0;
         len_q <= 4'd0;
         for (int i = 0; i < 10; i++) mem[i] <= 8'h00;
      end else if (clr) begin
         state <= FILL;
         wcnt  <= 4'd0;
         len_q <= 4'd0;
         for (int i = 0; i < 10; i++) mem[i] <= 8'h00;
      end else if (state == FILL) begin
         if (accept) begin
            mem[wcnt] <= in_data;
            if (completes) begin
               state <= HOLD;
               len_q <= wcnt_inc;
               wcnt  <= 4'd0;
            end else begin
               wcnt <= wcnt_inc;
            end
         end
      end else if (vec_ready) begin
         // entries clear so the next short vector reads zero past its length
         state <= FILL;
         len_q <= 4'd0;
         for (int i = 0; i < 10; i++) mem[i] <= 8'h00;
      end
   end

`endif

   assign x0 = xv[0];
   assign x1 = xv[1];
   assign x2 = xv[2];
   assign x3 = xv[3];
   assign x4 = xv[4];
   assign x5 = xv[5];
   assign x6 = xv[6];
   assign x7 = xv[7];
   assign x8 = xv[8];
   assign x9 = xv[9];

endmodule

// File: tb/tb_argmax_feeder.sv
// tb/tb_argmax_feeder.sv - scoreboard testbench for argmax_feeder

module tb_argmax_feeder;

   typedef struct packed {
      logic [9:0][7:0] x;
      logic [3:0]      len;
   } vec_t;

`ifdef ARGMAX_FEEDER_PINGPONG_EN
   localparam logic HOLD_RDY = 1'b1;
`else
   localparam logic HOLD_RDY = 1'b0;
`endif

   logic       clk;
   logic       rst_n;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_last;
   logic       in_ready;
   logic       clr;
   logic [7:0] x0, x1, x2, x3, x4, x5, x6, x7, x8, x9;
   logic [3:0] vec_len;
   logic       vec_valid;
   logic       vec_ready;

   logic [9:0][7:0] xa;
   assign xa = {x9, x8, x7, x6, x5, x4, x3, x2, x1, x0};

   int   checks = 0;
   int   errors = 0;
   vec_t sb [$];
   vec_t mon_e;
   vec_t tmp;

   argmax_feeder dut (
      .clk(clk), .rst_n(rst_n),
      .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
      .clr(clr),
      .x0(x0), .x1(x1), .x2(x2), .x3(x3), .x4(x4),
      .x5(x5), .x6(x6), .x7(x7), .x8(x8), .x9(x9),
      .vec_len(vec_len), .vec_valid(vec_valid), .vec_ready(vec_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk_seq(input int start, input int n);
      vec_t v;
      v.x   = '0;
      v.len = 4'(n);
      for (int i = 0; i < n; i++) v.x[i] = 8'(start + i);
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] d, input logic l);
      int n = 0;
      in_data  = d;
      in_valid = 1'b1;
      in_last  = l;
      @(negedge clk);
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: in_ready got 0 expected 1 for data %0h", d);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic pulse_ready();
      vec_ready = 1'b1;
      tick();
      vec_ready = 1'b0;
   endtask

   // monitor: every vector handshake pops the next expected vector
   always @(negedge clk) begin
      if (rst_n && !clr && vec_valid && vec_ready) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_vector: got x0=%0h len=%0d expected none", x0, vec_len);
         end else begin
            mon_e = sb.pop_front();
            chk("mon_vec_len", vec_len, mon_e.len);
            for (int i = 0; i < 10; i++) chk($sformatf("mon_x%0d", i), xa[i], mon_e.x[i]);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0; in_data = 8'h00; in_valid = 1'b0; in_last = 1'b0;
      clr = 1'b0; vec_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_vec_valid", vec_valid, 0);
      chk("rst_vec_len", vec_len, 0);
      chk("rst_x0", x0, 0);
      chk("rst_x9", x9, 0);
      rst_n = 1'b1;
      tick();
      chk("rst_in_ready", in_ready, 1);

      // full vector 10..19, latency and hold
      sb.push_back(mk_seq(10, 10));
      for (int i = 0; i < 10; i++) begin
         if (i == 9) chk("full_valid_early", vec_valid, 0);
         send(8'(10 + i), 1'b0);
      end
      chk("full_valid", vec_valid, 1);
      chk("full_len", vec_len, 10);
      chk("full_in_ready", in_ready, HOLD_RDY);
      repeat (3) tick();
      chk("full_hold_x0", x0, 10);
      chk("full_hold_x9", x9, 19);
      chk("full_hold_ready", in_ready, HOLD_RDY);
`ifndef ARGMAX_FEEDER_PINGPONG_EN
      in_data = 8'h99; in_valid = 1'b1;
      tick(); tick();
      in_valid = 1'b0;
      chk("stall_x0", x0, 10);
      chk("stall_x9", x9, 19);
      chk("stall_len", vec_len, 10);
`endif
      pulse_ready();
      chk("full_done_valid", vec_valid, 0);
      chk("full_done_ready", in_ready, 1);
      chk("full_done_x0", x0, 0);

      // short vector 5,7,3 held 5 cycles
      tmp = '0; tmp.x[0] = 8'd5; tmp.x[1] = 8'd7; tmp.x[2] = 8'd3; tmp.len = 4'd3;
      sb.push_back(tmp);
      send(8'd5, 1'b0); send(8'd7, 1'b0); send(8'd3, 1'b1);
      for (int c = 0; c < 5; c++) begin
         chk("short_valid", vec_valid, 1);
         chk("short_len", vec_len, 3);
         chk("short_x0", x0, 5);
         chk("short_x1", x1, 7);
         chk("short_x2", x2, 3);
         chk("short_x3", x3, 0);
         chk("short_x9", x9, 0);
         tick();
      end
      pulse_ready();
      chk("short_done_valid", vec_valid, 0);
      chk("short_done_ready", in_ready, 1);

      // vec_ready while idle is ignored
      vec_ready = 1'b1;
      tick(); tick();
      chk("idle_ready_valid", vec_valid, 0);
      sb.push_back(mk_seq(1, 2));
      send(8'd1, 1'b0); send(8'd2, 1'b1);
      chk("idle_ready_vec", vec_valid, 1);
      tick();
      chk("idle_ready_taken", vec_valid, 0);
      vec_ready = 1'b0;

      // clr mid-fill drops partial data and the concurrent sample
      for (int i = 0; i < 4; i++) send(8'(30 + i), 1'b0);
      in_data = 8'h77; in_valid = 1'b1; clr = 1'b1;
      tick();
      clr = 1'b0; in_valid = 1'b0;
      chk("clr_valid", vec_valid, 0);
      chk("clr_x0", x0, 0);
      chk("clr_x3", x3, 0);
      chk("clr_ready", in_ready, 1);
      sb.push_back(mk_seq(40, 10));
      for (int i = 0; i < 10; i++) send(8'(40 + i), 1'b0);
      chk("clr_next_valid", vec_valid, 1);
      chk("clr_next_x0", x0, 40);
      pulse_ready();

      // clr overrides vec_ready in hold
      send(8'd9, 1'b1);
      chk("clr_hold_valid", vec_valid, 1);
      clr = 1'b1; vec_ready = 1'b1;
      tick();
      clr = 1'b0; vec_ready = 1'b0;
      chk("clr_hold_dropped", vec_valid, 0);
      chk("clr_hold_x0", x0, 0);

      // asynchronous reset mid-hold
      send(8'd50, 1'b0); send(8'd51, 1'b0); send(8'd52, 1'b1);
      chk("rsth_valid", vec_valid, 1);
      rst_n = 1'b0;
      #1;
      chk("rsth_x0", x0, 0);
      chk("rsth_x2", x2, 0);
      chk("rsth_len", vec_len, 0);
      chk("rsth_vvalid", vec_valid, 0);
      repeat (2) @(posedge clk);
      #3;
      rst_n = 1'b1;
      @(negedge clk);
      chk("rsth_in_ready", in_ready, 1);
      chk("rsth_after_valid", vec_valid, 0);
      tick();
      sb.push_back(mk_seq(60, 1));
      send(8'd60, 1'b1);
      chk("rsth_next_x0", x0, 60);
      chk("rsth_next_len", vec_len, 1);
      pulse_ready();

`ifdef ARGMAX_FEEDER_PINGPONG_EN
      // continuous stream with consumer always ready
      vec_ready = 1'b1;
      sb.push_back(mk_seq(100, 10));
      sb.push_back(mk_seq(110, 10));
      for (int i = 0; i < 20; i++) begin
         chk("pp_stream_ready", in_ready, 1);
         send(8'(100 + i), 1'b0);
      end
      repeat (3) tick();
      vec_ready = 1'b0;
      chk("pp_stream_idle", vec_valid, 0);

      // both banks full stalls input, then drains in order
      sb.push_back(mk_seq(120, 10));
      sb.push_back(mk_seq(130, 10));
      for (int i = 0; i < 20; i++) send(8'(120 + i), 1'b0);
      chk("pp_full_ready", in_ready, 0);
      chk("pp_full_valid", vec_valid, 1);
      chk("pp_full_x0", x0, 120);
      pulse_ready();
      chk("pp_second_valid", vec_valid, 1);
      chk("pp_second_x0", x0, 130);
      chk("pp_second_ready", in_ready, 1);
      pulse_ready();
      chk("pp_drained", vec_valid, 0);
`endif

      repeat (5) tick();
      chk("sb_empty", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
